// File: rtl/arb_rr_oht.sv
// Round-robin arbiter with a registered binary grant and a one-hot view of it.
// A grant is held until it is accepted (rdy with the request still high) or
// until the granted requester withdraws. The pointer moves only on acceptance.

module arb_rr_oht_dec #(
  parameter int WIDTH          = 32,
  parameter int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
  input  logic [WIDTH_LOG-1:0] bin,
  input  logic                 en,
  output logic [WIDTH-1:0]     oht
);

  generate
    if (IMPLEMENTATION == 0) begin : g_shift
      // Decode by shifting a single one into place
      always_comb begin
        oht = '0;
        if (en) oht = WIDTH'(1) << bin;
      end
    end else begin : g_compare
      // Decode by comparing the index against every bit position
      always_comb begin
        oht = '0;
        for (int i = 0; i < WIDTH; i++) begin
          oht[i] = en && (bin == WIDTH_LOG'(i));
        end
      end
    end
  endgenerate

endmodule

module arb_rr_oht #(
  parameter int WIDTH          = 32,
  parameter int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  input  logic                 rdy,
  output logic                 vld,
  output logic [WIDTH_LOG-1:0] gnt_bin,
  output logic [WIDTH-1:0]     gnt_oht
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH_LOG-1:0] gnt_q, gnt_d;
  logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
  logic [WIDTH_LOG-1:0] ptr_sel;
  logic [WIDTH_LOG-1:0] sel;
  logic                 any_req;
  logic                 hit;
  logic                 transfer;

  assign any_req  = |req;
  assign hit      = req[gnt_q];
  assign transfer = (state_q == BUSY) && rdy && hit;

  // Search starts just past an accepted grant, otherwise at the stored pointer
  always_comb begin
    ptr_sel = ptr_q;
    if (transfer) ptr_sel = gnt_q + WIDTH_LOG'(1);
  end

  // First requester in cyclic order from ptr_sel; the nearest one wins
  always_comb begin
    sel = ptr_sel;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[ptr_sel + WIDTH_LOG'(i)]) sel = ptr_sel + WIDTH_LOG'(i);
    end
  end

  // State, grant and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: hold a pending grant, otherwise re-arbitrate or go idle
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = sel;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (transfer) ptr_d = ptr_sel;
        if (hit && !rdy) begin
          gnt_d = gnt_q;
        end else if (any_req) begin
          gnt_d = sel;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from the registers
  always_comb begin
    vld     = (state_q == BUSY);
    gnt_bin = gnt_q;
  end

  arb_rr_oht_dec #(
    .WIDTH          (WIDTH),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_dec (
    .bin (gnt_q),
    .en  (vld),
    .oht (gnt_oht)
  );

endmodule

// File: tb/tb_arb_rr_oht.sv
// Directed bench for the round-robin arbiter: a 4-requester vector table
// followed by a 32-requester full-load rotation sequence.

module tb_arb_rr_oht;

  logic        clk;
  logic        rst4, rdy4;
  logic [3:0]  req4;
  logic        vld4;
  logic [1:0]  bin4;
  logic [3:0]  oht4;

  logic        rst32, rdy32;
  logic [31:0] req32;
  logic        vld32;
  logic [4:0]  bin32;
  logic [31:0] oht32;

  int check_count;
  int pass_count;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       vld;
    logic [1:0] bin;
    logic [3:0] oht;
  } vec_t;

  vec_t vecs[25];
  int   hist[32];

  arb_rr_oht #(.WIDTH(4), .IMPLEMENTATION(0)) dut4 (
    .clk     (clk),
    .rst     (rst4),
    .req     (req4),
    .rdy     (rdy4),
    .vld     (vld4),
    .gnt_bin (bin4),
    .gnt_oht (oht4)
  );

  arb_rr_oht #(.WIDTH(32), .IMPLEMENTATION(1)) dut32 (
    .clk     (clk),
    .rst     (rst32),
    .req     (req32),
    .rdy     (rdy32),
    .vld     (vld32),
    .gnt_bin (bin32),
    .gnt_oht (oht32)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] q, input logic y);
    @(negedge clk);
    rst4 = r;
    req4 = q;
    rdy4 = y;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus32(input logic r, input logic [31:0] q, input logic y);
    @(negedge clk);
    rst32 = r;
    req32 = q;
    rdy32 = y;
    @(posedge clk);
    #1;
  endtask

  // Main test sequence
  initial begin
    check_count = 0;
    pass_count  = 0;
    rst4 = 1'b1; req4 = '0; rdy4 = 1'b0;
    rst32 = 1'b1; req32 = '0; rdy32 = 1'b0;

    // rst, req, rdy -> vld, gnt_bin, gnt_oht after the edge
    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[1]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[2]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[3]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[4]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[6]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[7]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[8]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[9]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
    vecs[10] = '{1'b0, 4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[11] = '{1'b0, 4'b1001, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[12] = '{1'b0, 4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[13] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[14] = '{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[15] = '{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[16] = '{1'b0, 4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[17] = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[18] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};
    vecs[19] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};
    vecs[20] = '{1'b0, 4'b1001, 1'b0, 1'b1, 2'd0, 4'b0001};
    vecs[21] = '{1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[22] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001};
    vecs[23] = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[24] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000};

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].rdy);
      checkOutput($sformatf("v%0d_vld", i), 32'(vld4), 32'(vecs[i].vld));
      checkOutput($sformatf("v%0d_bin", i), 32'(bin4), 32'(vecs[i].bin));
      checkOutput($sformatf("v%0d_oht", i), 32'(oht4), 32'(vecs[i].oht));
    end

    // 32 requesters all high with rdy: two full rotations, no bubbles
    for (int k = 0; k < 32; k++) hist[k] = 0;
    applyStimulus32(1'b1, '1, 1'b1);
    checkOutput("w32_reset_vld", 32'(vld32), 32'd0);
    checkOutput("w32_reset_oht", oht32, 32'd0);
    for (int c = 0; c < 64; c++) begin
      logic [31:0] exp_oht;
      exp_oht = 32'd1 << (c % 32);
      applyStimulus32(1'b0, '1, 1'b1);
      checkOutput($sformatf("w32_c%0d_vld", c), 32'(vld32), 32'd1);
      checkOutput($sformatf("w32_c%0d_bin", c), 32'(bin32), 32'(c % 32));
      checkOutput($sformatf("w32_c%0d_oht", c), oht32, exp_oht);
      hist[bin32]++;
    end
    for (int k = 0; k < 32; k++) begin
      checkOutput($sformatf("w32_hist%0d", k), 32'(hist[k]), 32'd2);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/arb_rr_oht.md
ARB_RR_OHT -- requirements
Module: arb_rr_oht

Interface
REQ-001 WIDTH, 32: number of requesters; SHALL be a power of two, >= 2.
REQ-002 IMPLEMENTATION, 0: SHALL be passed unchanged to the internal binary-to-one-hot decoder instance.
REQ-003 WIDTH_LOG, $clog2(WIDTH): localparam; SHALL set the width of binary indices.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 req  input  WIDTH  SHALL carry per-requester request flags; bit i is requester i.
REQ-007 rdy  input  1  SHALL indicate that the shared resource accepts the current grant.
REQ-008 vld  output  1  SHALL indicate that a grant is valid.
REQ-009 gnt_bin  output  WIDTH_LOG  SHALL give the granted requester index (binary).
REQ-010 gnt_oht  output  WIDTH  SHALL give the granted requester (one-hot), decoded from gnt_bin.

Function
REQ-011 State SHALL be IDLE (vld=0) or BUSY (vld=1); vld SHALL be driven directly from a register.
REQ-012 Pointer ptr (WIDTH_LOG bits) SHALL hold the highest-priority index; priority SHALL run cyclically ptr, ptr+1, ..., ptr-1 mod WIDTH.
REQ-013 Selection SHALL be the first set bit of req in cyclic order starting at ptr.
REQ-014 IDLE with req!=0 at edge N: gnt_bin SHALL be loaded with the selection and state SHALL be BUSY from cycle N+1 (1-cycle latency).
REQ-015 IDLE with req==0: state SHALL remain IDLE; gnt_bin and ptr SHALL hold.
REQ-016 gnt_oht SHALL be all-zero when vld=0 and SHALL equal the decode of gnt_bin when vld=1.
REQ-017 Transfer SHALL occur on a cycle where vld=1, rdy=1 and req[gnt_bin]=1.
REQ-018 On transfer, ptr SHALL become gnt_bin+1 mod WIDTH (WIDTH-1 wraps to 0).
REQ-019 On transfer with req!=0, the next grant SHALL be selected in the same cycle using the updated ptr; BUSY SHALL persist with no idle bubble (back-to-back).
REQ-020 On transfer with req==0, state SHALL become IDLE.
REQ-021 BUSY, rdy=0, req[gnt_bin]=1: gnt_bin SHALL hold (grant stable until accepted), regardless of other req bits.
REQ-022 BUSY, req[gnt_bin]=0 (abort, either rdy value): no transfer; ptr SHALL hold; re-arbitration SHALL follow REQ-019/REQ-020 rules but with the unchanged ptr.
REQ-023 A sole persistent requester SHALL be granted on every cycle (full throughput).
REQ-024 Any requester held high SHALL be granted within WIDTH transfers (starvation-free).

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, vld=0, gnt_bin=0, gnt_oht=0, ptr=0, overriding all other inputs, including mid-grant.
REQ-026 The first cycle after rst deasserts SHALL behave as IDLE; req present in that cycle SHALL yield vld=1 in the following cycle.

Verification
REQ-027 WIDTH=4, reset, req=4'b1010, rdy=1 held -> vld=1 with gnt_bin=1, gnt_oht=4'b0010; next cycle gnt_bin=3; next cycle gnt_bin=1 (alternation, no bubble).
REQ-028 WIDTH=4, req=4'b0100, rdy=0 for 3 cycles then 1 -> gnt_bin=2 stable all 3 cycles; transfer on 4th; ptr=3 after.
REQ-029 WIDTH=4, ptr=3 (after grant 2), req=4'b1001 -> gnt_bin=3; after transfer ptr wraps to 0, next gnt_bin=0.
REQ-030 WIDTH=4, grant on 1 with rdy=0, then req[1] drops while req=4'b0100 -> next cycle gnt_bin=2, ptr unchanged; if req=0 instead -> vld=0.
REQ-031 rst asserted while vld=1, rdy=0 -> next cycle vld=0, gnt_oht=0, ptr=0; release rst with req=4'b1111 -> gnt_bin=0 one cycle later.
REQ-032 WIDTH=32, all req high, rdy=1 for 64 cycles -> gnt_bin sequence 0..31, 0..31; each index granted exactly twice.
